// File: rtl/qk_seq_ctrl.sv
// qk_seq_ctrl: instruction sequencer for fullchip; runs Q/K write, load, execute,
// ofifo->pmem, accumulate and divide on start. Define QK_SEQ_STEP_EN for single-step HOLD mode.
module qk_seq_ctrl #(
    parameter int bw          = 8,
    parameter int pr          = 16,
    parameter int col         = 8,
    parameter int total_cycle = 8,
    parameter int gap         = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
`ifdef QK_SEQ_STEP_EN
    input  logic             step,
`endif
    input  logic             in_valid,
    input  logic [pr*bw-1:0] in_data,
    output logic             in_ready,
    output logic [pr*bw-1:0] mem_in,
    output logic [18:0]      inst,
    output logic             busy,
    output logic             done,
    output logic [3:0]       phase
);

    if (bw < 1 || pr < 1 || col < 1 || col > 16 || total_cycle < 1 || total_cycle > 16 ||
        gap < 0 || gap > 255) begin : g_param_check
        $error("qk_seq_ctrl: parameter outside supported range");
    end

    localparam int B_ACC = 18, B_DIV = 17, B_OFIFO = 16, B_EXEC = 7, B_LOAD = 6;
    localparam int B_QRD = 5, B_QWR = 4, B_KRD = 3, B_KWR = 2, B_PRD = 1, B_PWR = 0;

    localparam logic [7:0] T_L   = 8'(total_cycle);
    localparam logic [7:0] C_L   = 8'(col);
    localparam logic [7:0] GAP_L = 8'(gap);
`ifdef QK_SEQ_STEP_EN
    localparam logic [7:0] KWR_TAIL = 8'd1;
`else
    localparam logic [7:0] KWR_TAIL = 8'd3;
`endif

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0, S_QWR  = 4'd1, S_KWR  = 4'd2, S_LOAD = 4'd3, S_LGAP = 4'd4,
        S_EXEC  = 4'd5, S_EGAP = 4'd6, S_OFIFO = 4'd7, S_ACC = 4'd8, S_DIV  = 4'd9
`ifdef QK_SEQ_STEP_EN
        , S_HOLD = 4'd10
`endif
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         n_q, n_d;
    logic [1:0]         sub_q, sub_d;
    logic [18:0]        inst_q, inst_d;
    logic [pr*bw-1:0]   mem_in_q, mem_in_d;
    logic               in_ready_q, in_ready_d;
    logic               busy_q, busy_d, done_q, done_d;
    logic [3:0]         phase_q, phase_d;
    logic               hs, wr;
    logic [3:0]         addr_m1;
`ifdef QK_SEQ_STEP_EN
    state_t             ret_q, ret_d;
`endif

    // Host port: a vector transfers on any cycle where in_valid && in_ready are both high;
    // in_ready is registered, so it reflects whether a slot is free in the current cycle.
    assign hs = in_valid & in_ready_q;

    always_comb begin
        state_d = state_q;
        n_d     = n_q + 8'd1;
        sub_d   = 2'd0;
        done_d  = 1'b0;
        wr      = 1'b0;
`ifdef QK_SEQ_STEP_EN
        ret_d   = ret_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                n_d = 8'd0;
                if (start && !done_q) state_d = S_QWR;
            end
            S_QWR: begin
                if (n_q < T_L) begin
                    wr  = hs;
                    n_d = hs ? n_q + 8'd1 : n_q;
                end else if (n_q == T_L + 8'd1) begin
                    state_d = S_KWR;
                    n_d     = 8'd0;
                end
            end
            S_KWR: begin
                if (n_q < C_L) begin
                    wr  = hs;
                    n_d = hs ? n_q + 8'd1 : n_q;
                end else if (n_q == C_L + KWR_TAIL) begin
                    n_d = 8'd0;
`ifdef QK_SEQ_STEP_EN
                    state_d = S_HOLD;
                    ret_d   = S_LOAD;
`else
                    state_d = S_LOAD;
`endif
                end
            end
            S_LOAD: if (n_q == C_L + 8'd2) begin
                n_d = 8'd0;
`ifdef QK_SEQ_STEP_EN
                state_d = S_HOLD;
                ret_d   = S_EXEC;
`else
                state_d = (GAP_L != 8'd0) ? S_LGAP : S_EXEC;
`endif
            end
            S_LGAP: if (n_q == GAP_L - 8'd1) begin
                n_d     = 8'd0;
                state_d = S_EXEC;
            end
            S_EXEC: if (n_q == T_L) begin
                n_d = 8'd0;
`ifdef QK_SEQ_STEP_EN
                state_d = S_HOLD;
                ret_d   = S_OFIFO;
`else
                state_d = (GAP_L != 8'd0) ? S_EGAP : S_OFIFO;
`endif
            end
            S_EGAP: if (n_q == GAP_L - 8'd1) begin
                n_d     = 8'd0;
                state_d = S_OFIFO;
            end
            S_OFIFO: if (n_q == T_L) begin
                n_d = 8'd0;
`ifdef QK_SEQ_STEP_EN
                state_d = S_HOLD;
                ret_d   = S_ACC;
`else
                state_d = S_ACC;
`endif
            end
            S_ACC: if (n_q == C_L + 8'd1) begin
                n_d = 8'd0;
`ifdef QK_SEQ_STEP_EN
                state_d = S_HOLD;
                ret_d   = S_DIV;
`else
                state_d = S_DIV;
`endif
            end
            S_DIV: begin
                // n is the slot index, sub the cycle within the 3-cycle slot
                n_d   = n_q;
                sub_d = sub_q + 2'd1;
                if (sub_q == 2'd2) begin
                    sub_d = 2'd0;
                    n_d   = n_q + 8'd1;
                    if (n_q == C_L) begin
                        state_d = S_IDLE;
                        n_d     = 8'd0;
                        done_d  = 1'b1;
                    end
                end
            end
`ifdef QK_SEQ_STEP_EN
            S_HOLD: begin
                n_d = 8'd0;
                if (step) state_d = ret_q;
            end
`endif
            default: state_d = S_IDLE;
        endcase

        // Registered outputs are decoded from the state being entered.
        inst_d   = '0;
        addr_m1  = n_d[3:0] - 4'd1;
        mem_in_d = wr ? in_data : mem_in_q;
        case (state_d)
            S_QWR, S_KWR: begin
                inst_d[B_QWR] = wr && (state_d == S_QWR);
                inst_d[B_KWR] = wr && (state_d == S_KWR);
                if (wr) inst_d[15:12] = n_q[3:0];
                else if (n_d < ((state_d == S_QWR) ? T_L : C_L)) inst_d[15:12] = inst_q[15:12];
            end
            S_LOAD: begin
                inst_d[B_LOAD] = (n_d <= C_L + 8'd1);
                inst_d[B_KRD]  = (n_d >= 8'd1) && (n_d <= C_L);
                if (n_d >= 8'd2 && n_d <= C_L) inst_d[15:12] = addr_m1;
            end
            S_EXEC: if (n_d < T_L) begin
                inst_d[B_EXEC] = 1'b1;
                inst_d[B_QRD]  = 1'b1;
                inst_d[15:12]  = n_d[3:0];
            end
            S_OFIFO: if (n_d < T_L) begin
                inst_d[B_OFIFO] = 1'b1;
                inst_d[B_PWR]   = 1'b1;
                inst_d[11:8]    = n_d[3:0];
            end
            S_ACC: begin
                inst_d[B_ACC] = (n_d <= C_L);
                inst_d[B_PRD] = (n_d >= 8'd1) && (n_d <= C_L);
                if (n_d >= 8'd2 && n_d <= C_L) inst_d[11:8] = addr_m1;
            end
            S_DIV: begin
                inst_d[B_PRD] = 1'b1;
                inst_d[B_DIV] = (sub_d == 2'd0);
                inst_d[11:8]  = n_d[3:0];
            end
            default: ;
        endcase
        in_ready_d = ((state_d == S_QWR) && (n_d < T_L)) || ((state_d == S_KWR) && (n_d < C_L));
        busy_d     = (state_d != S_IDLE);
        phase_d    = state_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            n_q        <= 8'd0;
            sub_q      <= 2'd0;
            inst_q     <= '0;
            mem_in_q   <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            phase_q    <= 4'd0;
`ifdef QK_SEQ_STEP_EN
            ret_q      <= S_IDLE;
`endif
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            sub_q      <= sub_d;
            inst_q     <= inst_d;
            mem_in_q   <= mem_in_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            phase_q    <= phase_d;
`ifdef QK_SEQ_STEP_EN
            ret_q      <= ret_d;
`endif
        end
    end

    assign inst     = inst_q;
    assign mem_in   = mem_in_q;
    assign in_ready = in_ready_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign phase    = phase_q;

endmodule

// File: tb/tb_qk_seq_ctrl.sv
// Testbench for qk_seq_ctrl: a trace model expands each pass into per-cycle expected outputs,
// which a monitor compares against the DUT through an expected queue.
`timescale 1ns/1ps
module tb_qk_seq_ctrl;
    localparam int BW = 8, PR = 16, COL = 8, TC = 8, GAP = 10;
    localparam int MW = PR * BW;
    localparam int W  = 19 + MW + 7;
    localparam int I_ACC = 18, I_DIV = 17, I_OF = 16, I_EXEC = 7, I_LOAD = 6, I_QRD = 5;
    localparam int I_QWR = 4, I_KRD = 3, I_KWR = 2, I_PRD = 1, I_PWR = 0;

    logic          clk = 1'b0;
    logic          reset, start, in_valid;
    logic [MW-1:0] in_data;
    logic          in_ready, busy, done;
    logic [MW-1:0] mem_in;
    logic [18:0]   inst;
    logic [3:0]    phase;
`ifdef QK_SEQ_STEP_EN
    logic          step = 1'b1;
`endif

    qk_seq_ctrl #(.bw(BW), .pr(PR), .col(COL), .total_cycle(TC), .gap(GAP)) dut (
        .clk(clk), .reset(reset), .start(start),
`ifdef QK_SEQ_STEP_EN
        .step(step),
`endif
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .mem_in(mem_in), .inst(inst), .busy(busy), .done(done), .phase(phase)
    );

    always #5 clk = ~clk;

    // Per-cycle plan: the inputs to drive and the outputs expected in that same cycle.
    logic [W-1:0]  plan_q[$];
    logic          drv_start_q[$];
    logic          drv_valid_q[$];
    logic [MW-1:0] drv_data_q[$];
    logic [W-1:0]  exp_q[$];
    logic [MW-1:0] mdl_mem;
    int            errors = 0, checks = 0, div_seen = 0, done_seen = 0;

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [MW-1:0] rdata();
        logic [MW-1:0] r;
        for (int j = 0; j < MW / 32; j++) r[j*32 +: 32] = $urandom();
        return r;
    endfunction

    task automatic emit(input logic [18:0] i, input logic rdy, input logic [3:0] ph, input logic dn,
                        input logic st, input logic v, input logic [MW-1:0] d);
        plan_q.push_back({i, mdl_mem, rdy, (ph != 4'd0), dn, ph});
        drv_start_q.push_back(st);
        drv_valid_q.push_back(v);
        drv_data_q.push_back(d);
    endtask

    // Busy cycle with no host slot: start and in_valid are randomized and must be ignored.
    task automatic emit_b(input logic [18:0] i, input logic [3:0] ph);
        emit(i, 1'b0, ph, 1'b0, rnd(), rnd(), rdata());
    endtask

    // mode 0: valid always high, 1: drop valid 3 cycles after Q vector 2, 2: random valid
    task automatic gen_write(input int lim, input int wbit, input logic [3:0] ph, input int mode,
                             input bit is_q);
        int k, drop;
        logic [3:0] addr;
        logic wr, rdy, v;
        logic [MW-1:0] d, d_prev;
        logic [18:0] i;
        k = 0; drop = 0; addr = 4'd0; wr = 1'b0; d_prev = '0;
        while (1) begin
            i = '0;
            i[15:12] = addr;
            i[wbit] = wr;
            if (wr) mdl_mem = d_prev;
            rdy = (k < lim);
            d = rdata();
            if (drop > 0) begin
                v = 1'b0;
                drop--;
            end else if (mode == 2) v = ($urandom_range(0, 3) != 0);
            else v = 1'b1;
            emit(i, rdy, ph, 1'b0, rnd(), v, d);
            if (!rdy) break;
            wr = v;
            if (wr) begin
                addr = 4'(k);
                d_prev = d;
                k++;
            end
            if (is_q && mode == 1 && wr && k == 3) drop = 3;
        end
    endtask

    task automatic gen_pass(input int mode, input bit abort, input int idle_after);
        logic [18:0] i;
        emit('0, 1'b0, 4'd0, 1'b0, 1'b1, rnd(), rdata());
        gen_write(TC, I_QWR, 4'd1, mode, 1'b1);
        emit_b('0, 4'd1);
        gen_write(COL, I_KWR, 4'd2, (mode == 2) ? 2 : 0, 1'b0);
        for (int n = 0; n < 3; n++) emit_b('0, 4'd2);
        for (int n = 0; n <= COL + 2; n++) begin
            i = '0;
            i[I_LOAD] = (n <= COL + 1);
            i[I_KRD]  = (n >= 1 && n <= COL);
            if (n >= 2 && n <= COL) i[15:12] = 4'(n - 1);
            emit_b(i, 4'd3);
        end
        for (int n = 0; n < GAP; n++) emit_b('0, 4'd4);
        for (int n = 0; n <= TC; n++) begin
            i = '0;
            if (n < TC) begin
                i[I_EXEC] = 1'b1;
                i[I_QRD]  = 1'b1;
                i[15:12]  = 4'(n);
            end
            emit_b(i, 4'd5);
            if (abort && n == 4) return;
        end
        for (int n = 0; n < GAP; n++) emit_b('0, 4'd6);
        for (int n = 0; n <= TC; n++) begin
            i = '0;
            if (n < TC) begin
                i[I_OF]  = 1'b1;
                i[I_PWR] = 1'b1;
                i[11:8]  = 4'(n);
            end
            emit_b(i, 4'd7);
        end
        for (int n = 0; n <= COL + 1; n++) begin
            i = '0;
            i[I_ACC] = (n <= COL);
            i[I_PRD] = (n >= 1 && n <= COL);
            if (n >= 2 && n <= COL) i[11:8] = 4'(n - 1);
            emit_b(i, 4'd8);
        end
        for (int s = 0; s <= COL; s++) begin
            for (int j = 0; j < 3; j++) begin
                i = '0;
                i[I_PRD] = 1'b1;
                i[I_DIV] = (j == 0);
                i[11:8]  = 4'(s);
                emit_b(i, 4'd9);
            end
        end
        emit('0, 1'b0, 4'd0, 1'b1, rnd(), rnd(), rdata());
        for (int n = 0; n < idle_after; n++) emit('0, 1'b0, 4'd0, 1'b0, 1'b0, rnd(), rdata());
    endtask

    // Drives one cycle per plan entry; with abort, reset is raised in the last planned cycle.
    task automatic play(input bit abort);
        while (plan_q.size() > 0) begin
            @(posedge clk);
            #1;
            start    = drv_start_q.pop_front();
            in_valid = drv_valid_q.pop_front();
            in_data  = drv_data_q.pop_front();
            exp_q.push_back(plan_q.pop_front());
            if (abort && plan_q.size() == 0) reset = 1'b1;
        end
        if (abort) begin
            mdl_mem = '0;
            @(posedge clk);
            #1;
            reset = 1'b0;
            start = 1'b0;
            in_valid = 1'b0;
            exp_q.push_back({19'd0, mdl_mem, 1'b0, 1'b0, 1'b0, 4'd0});
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [W-1:0] e;
            logic [W-1:0] a;
            e = exp_q.pop_front();
            a = {inst, mem_in, in_ready, busy, done, phase};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL outputs t=%0t: got inst=%h mem_in=%h rdy=%b busy=%b done=%b phase=%0d, exp inst=%h mem_in=%h rdy=%b busy=%b done=%b phase=%0d",
                         $time, a[W-1 -: 19], a[W-20 -: MW], a[6], a[5], a[4], a[3:0],
                         e[W-1 -: 19], e[W-20 -: MW], e[6], e[5], e[4], e[3:0]);
            end
            if (inst[I_DIV] === 1'b1) div_seen++;
            if (done === 1'b1) done_seen++;
        end
    end

    initial begin
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
        mdl_mem = '0;
        @(posedge clk);
        for (int n = 0; n < 3; n++) begin
            @(posedge clk);
            #1;
            if (n == 2) reset = 1'b0;
            exp_q.push_back({19'd0, mdl_mem, 1'b0, 1'b0, 1'b0, 4'd0});
        end
        gen_pass(0, 1'b0, 2); play(1'b0);
        gen_pass(1, 1'b0, 0); play(1'b0);
        gen_pass(2, 1'b0, 2); play(1'b0);
        gen_pass(2, 1'b1, 0); play(1'b1);
        gen_pass(2, 1'b0, 3); play(1'b0);
        @(negedge clk);
        #1;
        checks++;
        if (div_seen != 4 * (COL + 1)) begin
            errors++;
            $display("FAIL div_pulses: got %0d, exp %0d", div_seen, 4 * (COL + 1));
        end
        checks++;
        if (done_seen != 4) begin
            errors++;
            $display("FAIL done_pulses: got %0d, exp %0d", done_seen, 4);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
